// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_pkg
//  Purpose  : Shared widths, packet type and arbiter state encoding for the
//             switch ingress arbiter.
//  Contents : SW_ADDR_W / SW_DATA_W  - switch source address / data widths
//             switch_pkt_t           - packed {addr, data} packet
//             arb_state_e            - output register occupancy state
//  Revision : 1.0  initial release
// ============================================================================
package switch_pkg;

    localparam int SW_ADDR_W = 48;
    localparam int SW_DATA_W = 32;

    typedef struct packed {
        logic [SW_ADDR_W-1:0] addr;
        logic [SW_DATA_W-1:0] data;
    } switch_pkt_t;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

endpackage : switch_pkg
`default_nettype wire

// File: rtl/switch_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : switch_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first requesting
//             port found searching upward from rr_ptr+1 with modulo wrap.
//  Ports    : req      in   NUM_PORTS  request vector
//             rr_ptr   in   PTR_W      index of the most recent winner
//             pick     out  PTR_W      selected port (0 when any_req=0)
//             any_req  out  1          at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module switch_rr_pick
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [PTR_W-1:0]     pick,
    output logic                 any_req
);

    // Walk offsets 1..NUM_PORTS so rr_ptr itself is visited last; that makes
    // the previous winner lowest priority and keeps a lone requester served.
    always_comb begin : p_pick
        int                 idx;
        logic [PTR_W-1:0]   w_sel;
        idx     = 0;
        w_sel   = '0;
        pick    = '0;
        any_req = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx   = (int'(rr_ptr) + off) % NUM_PORTS;
            w_sel = PTR_W'(idx);
            if (!any_req && req[w_sel]) begin
                pick    = w_sel;
                any_req = 1'b1;
            end
        end
    end

endmodule : switch_rr_pick
`default_nettype wire

// File: rtl/switch_ingress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : switch_ingress_arbiter
//  Purpose  : Work-conserving round-robin arbiter sharing the switch source
//             port between NUM_PORTS valid/ready requesters. The winner is
//             captured in a one-entry output register (1-cycle latency,
//             1 packet/cycle sustained).
//  Ports    : clk, rst_n                 clock, async active-low reset
//             req_valid/addr/data        per-port request (packed by port)
//             req_ready                  one-hot (or zero) accept strobe
//             out_valid/addr/data/port   output register to the switch
//             out_ready                  switch accepts this cycle
//             busy                       out_valid or any req_valid
//  Option   : `define SWITCH_ARB_STATS_EN adds stats_clr input and
//             grant_cnt output (16-bit saturating accept count per port).
//  Revision : 1.0  initial release
// ============================================================================
module switch_ingress_arbiter
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*SW_ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*SW_DATA_W-1:0] req_data,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic                           out_valid,
    output logic [SW_ADDR_W-1:0]           out_addr,
    output logic [SW_DATA_W-1:0]           out_data,
    input  logic                           out_ready,
    output logic [PTR_W-1:0]               out_port,
`ifdef SWITCH_ARB_STATS_EN
    input  logic                           stats_clr,
    output logic [NUM_PORTS*16-1:0]        grant_cnt,
`endif
    output logic                           busy
);

    arb_state_e        r_state;
    switch_pkt_t       r_pkt;
    logic [PTR_W-1:0]  r_port;
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [PTR_W-1:0]  w_pick;
    logic              w_any_req;
    logic              w_load_en;
    logic              w_accept;
    switch_pkt_t       w_pkt;

    switch_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (r_rr_ptr),
        .pick    (w_pick),
        .any_req (w_any_req)
    );

    // The register can take a new packet when empty, or when the current one
    // leaves this cycle. Gating with rst_n keeps every req_ready low while
    // reset is held, so no requester believes it was accepted.
    assign w_load_en = (r_state == ARB_EMPTY) || out_ready;
    assign w_accept  = rst_n && w_load_en && w_any_req;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_pick] = 1'b1;
        end
    end

    always_comb begin
        w_pkt.addr = req_addr[int'(w_pick)*SW_ADDR_W +: SW_ADDR_W];
        w_pkt.data = req_data[int'(w_pick)*SW_DATA_W +: SW_DATA_W];
    end

    // rr_ptr resets to the last port so port 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_EMPTY;
            r_pkt    <= '0;
            r_port   <= '0;
            r_rr_ptr <= PTR_W'(NUM_PORTS - 1);
        end else begin
            case (r_state)
                ARB_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ARB_FULL;
                    end
                end
                ARB_FULL: begin
                    if (out_ready && !w_accept) begin
                        r_state <= ARB_EMPTY;
                    end
                end
                default: r_state <= ARB_EMPTY;
            endcase
            if (w_accept) begin
                r_pkt    <= w_pkt;
                r_port   <= w_pick;
                r_rr_ptr <= w_pick;
            end
        end
    end

    assign out_valid = (r_state == ARB_FULL);
    assign out_addr  = r_pkt.addr;
    assign out_data  = r_pkt.data;
    assign out_port  = r_port;
    assign busy      = out_valid || (|req_valid);

`ifdef SWITCH_ARB_STATS_EN
    // Clear wins over a same-cycle increment; counts stick at all-ones.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (stats_clr) begin
                r_cnt <= '0;
            end else if (req_ready[g] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_cnt;
    end
`endif

endmodule : switch_ingress_arbiter
`default_nettype wire
